du_tx_arbiter: RTL and testbench

//  Shares the debug unit's single UART Tx (FIFO write port + tx_start/tx_done) among N_REQ byte-stream

---
 rtl/du_tx_arbiter.sv | 161 ++++++++++++++++
 tb/tb_du_tx_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/du_tx_arbiter.sv
// du_tx_arbiter
//   Shares the debug unit's single UART Tx (FIFO write strobe + tx_start/tx_done
//   handshake) among N_REQ byte-stream senders. Round-robin grant that is held
//   for a whole transaction, one byte in flight at a time, tx_done routed back
//   to the owner, and an idle timeout that revokes a stalled grant.
// Ports
//   clk, i_rst     clock, synchronous active-high reset
//   i_req          level request per sender, held for the whole transaction
//   i_tx_start     per-sender byte-send strobe
//   i_wdata        per-sender byte, sender i at [i*NB_UART_DATA +: NB_UART_DATA]
//   i_tx_done      UART byte-complete pulse
//   o_gnt          one-hot grant, 0 when no owner
//   o_tx_done      i_tx_done routed to the current owner only
//   o_tx_start     UART tx_start / FIFO write strobe (owner's strobe, same cycle)
//   o_tx_data      UART byte (owner's byte, same cycle)
//   o_timeout      1-cycle pulse when a grant is revoked by timeout
//   o_byte_count   bytes forwarded in the current/last grant
module du_tx_arbiter #(
  parameter int unsigned N_REQ        = 3,
  parameter int unsigned NB_UART_DATA = 8,
  parameter int unsigned NB_TIMEOUT   = 16,
  parameter int unsigned TIMEOUT      = 50000,
  parameter int unsigned NB_BYTE_CNT  = 16
) (
  input  logic                            clk,
  input  logic                            i_rst,
  input  logic [N_REQ-1:0]                i_req,
  input  logic [N_REQ-1:0]                i_tx_start,
  input  logic [N_REQ*NB_UART_DATA-1:0]   i_wdata,
  input  logic                            i_tx_done,
  output logic [N_REQ-1:0]                o_gnt,
  output logic [N_REQ-1:0]                o_tx_done,
  output logic                            o_tx_start,
  output logic [NB_UART_DATA-1:0]         o_tx_data,
  output logic                            o_timeout,
  output logic [NB_BYTE_CNT-1:0]          o_byte_count
);

  localparam int unsigned NB_OWNER = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_GRANT   = 4'b0010,
    ST_BUSY    = 4'b0100,
    ST_RELEASE = 4'b1000
  } state_t;

  state_t                  state_q, state_d;
  logic [NB_OWNER-1:0]     owner_q, owner_d;
  logic [NB_OWNER-1:0]     last_owner_q, last_owner_d;
  logic [NB_BYTE_CNT-1:0]  byte_cnt_q, byte_cnt_d;
  logic [NB_TIMEOUT-1:0]   idle_cnt_q, idle_cnt_d;

  logic [NB_UART_DATA-1:0] wdata_arr [N_REQ];
  logic [NB_OWNER-1:0]     rr_idx;
  logic [NB_OWNER-1:0]     rr_pick;
  logic                    rr_found;

  // Unpack the flat byte bus into one lane per sender
  for (genvar g = 0; g < N_REQ; g++) begin : g_wdata
    assign wdata_arr[g] = i_wdata[g*NB_UART_DATA +: NB_UART_DATA];
  end

  // Round-robin pick: first requester after last_owner, wrapping mod N_REQ
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    rr_idx   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      rr_idx = NB_OWNER'((32'(last_owner_q) + k) % N_REQ);
      if (!rr_found && i_req[rr_idx]) begin
        rr_found = 1'b1;
        rr_pick  = rr_idx;
      end
    end
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_owner_q <= NB_OWNER'(N_REQ - 1);
      byte_cnt_q   <= '0;
      idle_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      byte_cnt_q   <= byte_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
    end
  end

  // Next-state and Tx routing
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    byte_cnt_d   = byte_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    o_gnt        = '0;
    o_tx_done    = '0;
    o_tx_start   = 1'b0;
    o_tx_data    = '0;
    o_timeout    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          owner_d    = rr_pick;
          byte_cnt_d = '0;
          idle_cnt_d = '0;
          state_d    = ST_GRANT;
        end
      end

      ST_GRANT: begin
        o_gnt[owner_q] = 1'b1;
        o_tx_start     = i_tx_start[owner_q];
        o_tx_data      = wdata_arr[owner_q];
        // A start in the same cycle beats a req drop or an expiring timeout
        if (i_tx_start[owner_q]) begin
          if (byte_cnt_q != '1) begin
            byte_cnt_d = byte_cnt_q + NB_BYTE_CNT'(1);
          end
          idle_cnt_d = '0;
          state_d    = ST_BUSY;
        end else if (!i_req[owner_q]) begin
          state_d = ST_RELEASE;
        end else if (idle_cnt_q == NB_TIMEOUT'(TIMEOUT - 1)) begin
          o_timeout = 1'b1;
          state_d   = ST_RELEASE;
        end else begin
          idle_cnt_d = idle_cnt_q + NB_TIMEOUT'(1);
        end
      end

      ST_BUSY: begin
        // Byte in flight: no new starts, no timeout, req drop waits for tx_done
        o_gnt[owner_q] = 1'b1;
        if (i_tx_done) begin
          o_tx_done[owner_q] = 1'b1;
          state_d = i_req[owner_q] ? ST_GRANT : ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        last_owner_d = owner_q;
        state_d      = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_byte_count = byte_cnt_q;

endmodule

// File: tb/tb_du_tx_arbiter.sv
// tb_du_tx_arbiter
//   Directed bench for du_tx_arbiter (N_REQ=3, 8-bit bytes, TIMEOUT=8).
//   Inputs are driven 1 time unit after the rising edge, outputs sampled 1 unit later.
module tb_du_tx_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned NB = 8;

  logic            clk = 1'b0;
  logic            i_rst;
  logic [N-1:0]    i_req;
  logic [N-1:0]    i_tx_start;
  logic [N*NB-1:0] i_wdata;
  logic            i_tx_done;
  logic [N-1:0]    o_gnt;
  logic [N-1:0]    o_tx_done;
  logic            o_tx_start;
  logic [NB-1:0]   o_tx_data;
  logic            o_timeout;
  logic [15:0]     o_byte_count;

  always #5 clk = ~clk;

  du_tx_arbiter #(
    .N_REQ(3), .NB_UART_DATA(8), .NB_TIMEOUT(16), .TIMEOUT(8), .NB_BYTE_CNT(16)
  ) dut (
    .clk(clk), .i_rst(i_rst), .i_req(i_req), .i_tx_start(i_tx_start),
    .i_wdata(i_wdata), .i_tx_done(i_tx_done), .o_gnt(o_gnt), .o_tx_done(o_tx_done),
    .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .o_timeout(o_timeout),
    .o_byte_count(o_byte_count)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst      = 1'b1;
    i_req      = '0;
    i_tx_start = '0;
    i_wdata    = '0;
    i_tx_done  = 1'b0;
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  // Entered while sender s owns GRANT; sends byte b, tx_done dly cycles later.
  // With drop, the owner lowers its req in the tx_done cycle.
  task automatic send_byte(input int s, input logic [7:0] b, input int dly, input bit drop);
    i_wdata[s*NB +: NB] = b;
    i_tx_start[s] = 1'b1;
    #1;
    check("tx_start", 32'(o_tx_start), 32'd1);
    check("tx_data", 32'(o_tx_data), 32'(b));
    tick();
    i_tx_start = '0;
    repeat (dly - 1) tick();
    if (drop) i_req[s] = 1'b0;
    i_tx_done = 1'b1;
    #1;
    check("tx_done_route", 32'(o_tx_done), 32'(1 << s));
    tick();
    i_tx_done = 1'b0;
  endtask

  logic [7:0] t1_bytes [4];

  initial begin
    t1_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};

    // Reset values
    do_reset();
    #1;
    check("rst_gnt", 32'(o_gnt), 32'd0);
    check("rst_start", 32'(o_tx_start), 32'd0);
    check("rst_bytecnt", 32'(o_byte_count), 32'd0);
    check("rst_timeout", 32'(o_timeout), 32'd0);

    // T1: single sender, four bytes
    i_req = 3'b001;
    tick();
    check("t1_gnt", 32'(o_gnt), 32'b001);
    for (int i = 0; i < 4; i++) send_byte(0, t1_bytes[i], 10, 1'b0);
    check("t1_bytecnt", 32'(o_byte_count), 32'd4);
    i_req = 3'b000;
    tick();
    check("t1_gnt_rel", 32'(o_gnt), 32'd0);
    tick();
    check("t1_gnt_idle", 32'(o_gnt), 32'd0);
    check("t1_bytecnt_hold", 32'(o_byte_count), 32'd4);

    // T2: round-robin order 0,2 then 0,1,2 from last_owner=2
    do_reset();
    i_req = 3'b101;
    tick();
    check("t2_gnt_a", 32'(o_gnt), 32'b001);
    send_byte(0, 8'hA0, 2, 1'b1);
    check("t2_gap_rel", 32'(o_gnt), 32'd0);
    tick();
    check("t2_gap_idle", 32'(o_gnt), 32'd0);
    tick();
    check("t2_gnt_b", 32'(o_gnt), 32'b100);
    send_byte(2, 8'hA2, 2, 1'b1);
    check("t2_gap_rel", 32'(o_gnt), 32'd0);
    tick();
    i_req = 3'b111;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t2_rr_gnt", 32'(o_gnt), 32'(1 << k));
      send_byte(k, 8'hB0 + 8'(k), 3, 1'b1);
      check("t2_rr_gap", 32'(o_gnt), 32'd0);
      tick();
      check("t2_rr_idle", 32'(o_gnt), 32'd0);
    end

    // T3: owner drops req while its byte is in flight
    do_reset();
    i_req = 3'b011;
    tick();
    check("t3_gnt", 32'(o_gnt), 32'b001);
    i_wdata[0 +: NB] = 8'h5A;
    i_tx_start[0] = 1'b1;
    tick();
    i_tx_start = '0;
    i_req[0]   = 1'b0;
    tick();
    check("t3_busy_gnt", 32'(o_gnt), 32'b001);
    tick();
    check("t3_busy_gnt2", 32'(o_gnt), 32'b001);
    i_tx_done = 1'b1;
    #1;
    check("t3_done", 32'(o_tx_done), 32'b001);
    tick();
    i_tx_done = 1'b0;
    check("t3_rel", 32'(o_gnt), 32'd0);
    tick();
    check("t3_idle", 32'(o_gnt), 32'd0);
    tick();
    check("t3_next", 32'(o_gnt), 32'b010);

    // T4: idle timeout revokes grant, then re-grant
    do_reset();
    i_req = 3'b010;
    tick();
    for (int c = 1; c <= 8; c++) begin
      check("t4_gnt", 32'(o_gnt), 32'b010);
      check("t4_timeout", 32'(o_timeout), (c == 8) ? 32'd1 : 32'd0);
      tick();
    end
    check("t4_revoked", 32'(o_gnt), 32'd0);
    check("t4_pulse_end", 32'(o_timeout), 32'd0);
    tick();
    tick();
    check("t4_regrant", 32'(o_gnt), 32'b010);

    // T5: non-owner start ignored, start during BUSY ignored, stray tx_done dropped
    do_reset();
    i_req = 3'b101;
    tick();
    i_wdata[0 +: NB]  = 8'h55;
    i_wdata[16 +: NB] = 8'hAA;
    i_tx_start = 3'b101;
    #1;
    check("t5_data", 32'(o_tx_data), 32'h55);
    tick();
    i_wdata[0 +: NB] = 8'h66;
    i_tx_start = 3'b101;
    #1;
    check("t5_busy_start", 32'(o_tx_start), 32'd0);
    tick();
    i_tx_start = '0;
    i_tx_done  = 1'b1;
    #1;
    check("t5_done", 32'(o_tx_done), 32'b001);
    tick();
    check("t5_bytecnt", 32'(o_byte_count), 32'd1);
    #1;
    check("t5_stray_done", 32'(o_tx_done), 32'd0);
    i_tx_done = 1'b0;
    i_req = 3'b000;
    tick();
    tick();

    // T6: reset mid-byte; last_owner is 0 here so req 011 goes to 1 first
    i_req = 3'b011;
    tick();
    check("t6_gnt", 32'(o_gnt), 32'b010);
    i_wdata[8 +: NB] = 8'hC3;
    i_tx_start[1] = 1'b1;
    tick();
    i_tx_start = '0;
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    i_tx_done = 1'b1;
    #1;
    check("t6_gnt_rst", 32'(o_gnt), 32'd0);
    check("t6_start_rst", 32'(o_tx_start), 32'd0);
    check("t6_done_drop", 32'(o_tx_done), 32'd0);
    check("t6_bytecnt_rst", 32'(o_byte_count), 32'd0);
    tick();
    i_tx_done = 1'b0;
    check("t6_first_gnt", 32'(o_gnt), 32'b001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
